// File: rtl/mcycle_seq.sv
// mcycle_seq: iterative 32-bit multiply / divide unit.
// One iteration per cycle: shift-add multiply (LSB first) and, when built
// with MCYCLE_DIV_EN defined, restoring shift-subtract divide (MSB first).
// Without MCYCLE_DIV_EN the divide datapath is absent and divide opcodes
// finish immediately with zero results.
// Sign handling is done outside the loop: magnitudes are latched at launch
// and the final value is negated on the way into the result registers.
module mcycle_seq (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  MCycleOp,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    output logic [31:0] Result1,
    output logic [31:0] Result2,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [5:0]  count;       // iterations completed; stops at 32
    logic [31:0] opnd;        // multiplicand (mul) or divisor (div) magnitude
    logic [63:0] acc;         // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [63:0] acc_next;
    logic [63:0] result_fix;  // acc_next with the result sign applied
    logic        neg_res;     // negate product / quotient
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic        last_iter;
`ifdef MCYCLE_DIV_EN
    logic        op_div;
    logic        neg_rem;     // remainder takes the dividend's sign
    logic [32:0] rem_sh;
    logic [32:0] diff;
`endif

    assign last_iter = (count == 6'd31);
    assign Done      = (state == DONE);

    // Operand magnitudes and signs presented at launch.
    always_comb begin
        a_neg = MCycleOp[0] & Operand1[31];
        b_neg = MCycleOp[0] & Operand2[31];
        a_mag = a_neg ? (~Operand1 + 32'd1) : Operand1;
        b_mag = b_neg ? (~Operand2 + 32'd1) : Operand2;
    end

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and Busy; Start is only looked at in IDLE.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned
        // (which would infer a latch).
        state_next = state;
        Busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    Busy = 1'b1;
`ifdef MCYCLE_DIV_EN
                    state_next = RUN;
`else
                    state_next = MCycleOp[1] ? DONE : RUN;
`endif
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One datapath iteration and the sign-corrected final value.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef MCYCLE_DIV_EN
        // Remainder is always below the divisor, so the shifted value fits
        // in 33 bits and diff[32] is a clean borrow flag.
        rem_sh = acc[63:31];
        diff   = rem_sh - {1'b0, opnd};
        if (op_div) begin
            acc_next = diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                : {diff[31:0],   acc[30:0], 1'b1};
        end
`endif
        result_fix = neg_res ? (~acc_next + 64'd1) : acc_next;
`ifdef MCYCLE_DIV_EN
        if (op_div) begin
            result_fix[31:0]  = neg_res ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
            result_fix[63:32] = neg_rem ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
        end
`endif
    end

    // Datapath registers: load at launch, iterate in RUN, publish on the
    // last iteration so results change only on entry to DONE.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count   <= 6'd0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            neg_res <= 1'b0;
            Result1 <= 32'd0;
            Result2 <= 32'd0;
`ifdef MCYCLE_DIV_EN
            op_div  <= 1'b0;
            neg_rem <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        count <= 6'd0;
`ifdef MCYCLE_DIV_EN
                        op_div <= MCycleOp[1];
                        if (MCycleOp[1]) begin
                            // Divide by zero keeps the quotient positive so it
                            // reads all ones; the remainder ends up as Operand1.
                            opnd    <= b_mag;
                            acc     <= {32'd0, a_mag};
                            neg_res <= (a_neg ^ b_neg) & (|Operand2);
                            neg_rem <= a_neg;
                        end else begin
                            opnd    <= a_mag;
                            acc     <= {32'd0, b_mag};
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= 1'b0;
                        end
`else
                        opnd    <= a_mag;
                        acc     <= {32'd0, b_mag};
                        neg_res <= a_neg ^ b_neg;
                        if (MCycleOp[1]) begin
                            Result1 <= 32'd0;
                            Result2 <= 32'd0;
                        end
`endif
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 6'd1;
                    if (last_iter) begin
                        Result1 <= result_fix[31:0];
                        Result2 <= result_fix[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
